// File: rtl/dac_pkg.sv
// Shared definitions for the DAC frame sequencer: frame geometry, default
// command byte, reset code, FSM encoding and the code-select arithmetic.
package dac_pkg;

    localparam int          FRAME_W     = 24;
    localparam logic [7:0]  DEFAULT_CMD = 8'h30;
    localparam logic [15:0] RESET_CODE  = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } dac_state_t;

    // Origin wins over +10 V; both beat normal mode. Sums widen by two bits so
    // that overflow and underflow can be detected before clamping to 16 bits.
    function automatic logic [15:0] select_code(
        input logic        calib_org,
        input logic        calib_10V,
        input logic [15:0] speed_code,
        input logic [15:0] dac_org,
        input logic [15:0] dac_width_10V
    );
        logic [16:0]        span_sum;
        logic signed [17:0] norm_sum;
        logic [15:0]        code;
        span_sum = {1'b0, dac_org} + {1'b0, dac_width_10V};
        norm_sum = $signed({2'b00, dac_org}) + $signed({{2{speed_code[15]}}, speed_code});
        if (calib_org)
            code = dac_org;
        else if (calib_10V)
            code = span_sum[16] ? 16'hFFFF : span_sum[15:0];
        else if (norm_sum[17])
            code = 16'h0000;
        else if (norm_sum[16])
            code = 16'hFFFF;
        else
            code = norm_sum[15:0];
        return code;
    endfunction

endpackage

// File: rtl/dac_spi_shift.sv
// Serialises one 24-bit frame MSB first: sclk low for the first half of each
// bit period and high for the second, sync_n low for the whole frame.
module dac_spi_shift
    import dac_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic               CLK_60,
    input  logic               RST,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               busy,
    output logic               frame_end,
    output logic               dac_sclk,
    output logic               dac_sync_n,
    output logic               dac_din
);

    localparam logic [4:0] HALF_CYC  = 5'(SCLK_DIV);
    localparam logic [4:0] LAST_CYC  = 5'(2 * SCLK_DIV - 1);
    localparam logic [4:0] LAST_BIT  = 5'(FRAME_W - 1);

    logic [4:0]         cyc_cnt;
    logic [4:0]         bit_cnt;
    logic [FRAME_W-1:0] shift_reg;

    assign frame_end = busy && (cyc_cnt == LAST_CYC) && (bit_cnt == LAST_BIT);

    always_ff @(posedge CLK_60) begin
        if (RST) begin
            busy       <= 1'b0;
            dac_sclk   <= 1'b0;
            dac_sync_n <= 1'b1;
            dac_din    <= 1'b0;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
        end else if (start) begin
            busy       <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_sync_n <= 1'b0;
            dac_din    <= frame[FRAME_W-1];
            shift_reg  <= {frame[FRAME_W-2:0], 1'b0};
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
        end else if (busy) begin
            if (cyc_cnt == LAST_CYC) begin
                cyc_cnt  <= '0;
                dac_sclk <= 1'b0;
                if (bit_cnt == LAST_BIT) begin
                    busy       <= 1'b0;
                    dac_sync_n <= 1'b1;
                    dac_din    <= 1'b0;
                end else begin
                    bit_cnt   <= bit_cnt + 5'd1;
                    dac_din   <= shift_reg[FRAME_W-1];
                    shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
                end
            end else begin
                cyc_cnt  <= cyc_cnt + 5'd1;
                dac_sclk <= ((cyc_cnt + 5'd1) >= HALF_CYC);
            end
        end
    end

endmodule

// File: rtl/dac_seq.sv
// DAC update sequencer: arbitrates update requests, computes the output code
// and drives one serial frame per request through dac_spi_shift.
module dac_seq
    import dac_pkg::*;
#(
    parameter int         SCLK_DIV = 2,
    parameter int         GAP_CYC  = 4,
    parameter logic [7:0] DAC_CMD  = DEFAULT_CMD
) (
    input  logic        CLK_60,
    input  logic        RST,
    input  logic        upd_req,
    input  logic [15:0] speed_code,
    input  logic [15:0] dac_org,
    input  logic [15:0] dac_width_10V,
    input  logic        calib_org,
    input  logic        calib_10V,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_din,
    output logic        busy,
    output logic        done,
    output logic [15:0] dac_code
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    dac_state_t  state;
    logic        pending;
    logic [3:0]  gap_cnt;
    logic [15:0] load_code;
    logic        spi_busy;
    logic        spi_frame_end;

    assign load_code = select_code(calib_org, calib_10V, speed_code, dac_org, dac_width_10V);

    dac_spi_shift #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shift (
        .CLK_60     (CLK_60),
        .RST        (RST),
        .start      (state == LOAD),
        .frame      ({DAC_CMD, load_code}),
        .busy       (spi_busy),
        .frame_end  (spi_frame_end),
        .dac_sclk   (dac_sclk),
        .dac_sync_n (dac_sync_n),
        .dac_din    (dac_din)
    );

    // Requests seen while a frame is in progress fold into a single pending flag.
    always_ff @(posedge CLK_60) begin
        if (RST) begin
            state    <= IDLE;
            pending  <= 1'b0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dac_code <= RESET_CODE;
        end else begin
            done <= 1'b0;
            if (upd_req && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (upd_req || pending) begin
                        state   <= LOAD;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    dac_code <= load_code;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (spi_frame_end || !spi_busy) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_seq.sv
// Self-checking bench for dac_seq: table vectors, randomized frames against a
// plain-arithmetic code model, and hand-written multi-frame/reset sequences.
module tb_dac_seq;

    logic        CLK_60 = 1'b0;
    logic        RST;
    logic        upd_req;
    logic [15:0] speed_code;
    logic [15:0] dac_org;
    logic [15:0] dac_width_10V;
    logic        calib_org;
    logic        calib_10V;
    logic        dac_sclk;
    logic        dac_sync_n;
    logic        dac_din;
    logic        busy;
    logic        done;
    logic [15:0] dac_code;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        co;
        logic        c10;
        logic [15:0] sp;
        logic [15:0] org;
        logic [15:0] w;
        logic [15:0] exp_code;
    } vec_t;

    vec_t vecs[9];

    dac_seq dut (
        .CLK_60        (CLK_60),
        .RST           (RST),
        .upd_req       (upd_req),
        .speed_code    (speed_code),
        .dac_org       (dac_org),
        .dac_width_10V (dac_width_10V),
        .calib_org     (calib_org),
        .calib_10V     (calib_10V),
        .dac_sclk      (dac_sclk),
        .dac_sync_n    (dac_sync_n),
        .dac_din       (dac_din),
        .busy          (busy),
        .done          (done),
        .dac_code      (dac_code)
    );

    always #8 CLK_60 = ~CLK_60;

    task automatic tick();
        @(posedge CLK_60);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic co, input logic c10, input logic [15:0] sp,
                                 input logic [15:0] org, input logic [15:0] w);
        calib_org     = co;
        calib_10V     = c10;
        speed_code    = sp;
        dac_org       = org;
        dac_width_10V = w;
    endtask

    // Reference: the code is the selected value computed as an ordinary integer, then clamped.
    function automatic logic [15:0] model_code(input logic co, input logic c10, input logic [15:0] sp,
                                               input logic [15:0] org, input logic [15:0] w);
        int v;
        int s;
        s = $signed(sp);
        if (co)
            v = int'(org);
        else if (c10)
            v = int'(org) + int'(w);
        else
            v = int'(org) + s;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        return v[15:0];
    endfunction

    task automatic run_frame(input string tag, input logic [15:0] exp_code, input bit scramble);
        int          cyc;
        int          low_cnt;
        int          rise_cnt;
        int          done_cyc;
        logic [23:0] bits;
        logic        prev_sclk;
        tick();
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        cyc = 1;
        checkOutput({tag, "_busy_load"}, 32'(busy), 32'd1);
        low_cnt = 0; rise_cnt = 0; done_cyc = -1; bits = '0; prev_sclk = 1'b0;
        while (cyc < 400) begin
            if (scramble && cyc == 4)
                applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            if (!dac_sync_n) low_cnt++;
            if (dac_sclk && !prev_sclk) begin
                bits = {bits[22:0], dac_din};
                rise_cnt++;
            end
            prev_sclk = dac_sclk;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'd102);
        checkOutput({tag, "_sync_low"}, 32'(low_cnt), 32'd96);
        checkOutput({tag, "_sclk_rises"}, 32'(rise_cnt), 32'd24);
        checkOutput({tag, "_frame_bits"}, 32'(bits), {8'h00, 8'h30, exp_code});
        checkOutput({tag, "_dac_code"}, 32'(dac_code), 32'(exp_code));
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    // Request at cycle 0 plus extra one-cycle requests at the listed cycles (-1 = none).
    task automatic run_seq(input string tag, input int r1, input int r2, input int r3);
        int   cyc;
        int   done_cnt;
        int   frames;
        int   d1;
        int   d2;
        logic busy_after;
        logic prev_sync;
        tick();
        upd_req = 1'b1;
        cyc = 0;
        done_cnt = 0; frames = 0; d1 = -1; d2 = -1; busy_after = 1'b0; prev_sync = 1'b1;
        while (cyc < 320) begin
            tick();
            cyc++;
            upd_req = (cyc == r1) || (cyc == r2) || (cyc == r3);
            if (prev_sync && !dac_sync_n) frames++;
            prev_sync = dac_sync_n;
            if (d1 >= 0 && cyc == d1 + 1) busy_after = busy;
            if (done) begin
                done_cnt++;
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
        end
        upd_req = 1'b0;
        checkOutput({tag, "_done_count"}, 32'(done_cnt), 32'd2);
        checkOutput({tag, "_frame_count"}, 32'(frames), 32'd2);
        checkOutput({tag, "_first_done"}, 32'(d1), 32'd102);
        checkOutput({tag, "_second_done"}, 32'(d2), 32'd204);
        checkOutput({tag, "_busy_after_done"}, 32'(busy_after), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"origin",      1'b1, 1'b0, 16'h0000, 16'h8000, 16'h0000, 16'h8000};
        vecs[1] = '{"span10v",     1'b0, 1'b1, 16'h0000, 16'd32768, 16'd27692, 16'hEC2C};
        vecs[2] = '{"span10v_sat", 1'b0, 1'b1, 16'h0000, 16'hC000, 16'd32692, 16'hFFFF};
        vecs[3] = '{"clamp_low",   1'b0, 1'b0, 16'h8000, 16'd27768, 16'h0000, 16'h0000};
        vecs[4] = '{"clamp_high",  1'b0, 1'b0, 16'd100,  16'hFFF0, 16'h0000, 16'hFFFF};
        vecs[5] = '{"norm_pos",    1'b0, 1'b0, 16'h0100, 16'h8000, 16'h1234, 16'h8100};
        vecs[6] = '{"norm_neg",    1'b0, 1'b0, 16'hFFFF, 16'h8000, 16'h1234, 16'h7FFF};
        vecs[7] = '{"priority",    1'b1, 1'b1, 16'h1234, 16'h1111, 16'h2222, 16'h1111};
        vecs[8] = '{"norm_top",    1'b0, 1'b0, 16'h00FF, 16'hFF00, 16'h0000, 16'hFFFF};

        RST = 1'b1;
        upd_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) tick();
        checkOutput("reset_sync_n", 32'(dac_sync_n), 32'd1);
        checkOutput("reset_sclk", 32'(dac_sclk), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_code", 32'(dac_code), 32'h8000);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].co, vecs[i].c10, vecs[i].sp, vecs[i].org, vecs[i].w);
            run_frame(vecs[i].name, vecs[i].exp_code, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            logic        co;
            logic        c10;
            logic [15:0] sp;
            logic [15:0] org;
            logic [15:0] w;
            int          mode;
            mode = $urandom_range(0, 3);
            co  = (mode == 0) || (mode == 3);
            c10 = (mode == 1) || (mode == 3);
            sp  = 16'($urandom);
            org = 16'($urandom);
            w   = 16'($urandom);
            applyStimulus(co, c10, sp, org, w);
            run_frame("random", model_code(co, c10, sp, org, w), 1'b1);
        end

        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0000);
        run_seq("collapse", 10, 30, 60);
        run_seq("same_cycle", 102, -1, -1);

        begin
            int done_seen;
            tick();
            upd_req = 1'b1;
            tick();
            upd_req = 1'b0;
            repeat (51) tick();
            RST = 1'b1;
            tick();
            RST = 1'b0;
            checkOutput("abort_sync_n", 32'(dac_sync_n), 32'd1);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_code", 32'(dac_code), 32'h8000);
            done_seen = 0;
            repeat (120) begin
                if (done) done_seen++;
                tick();
            end
            checkOutput("abort_no_done", 32'(done_seen), 32'd0);
            applyStimulus(1'b0, 1'b0, 16'hFF38, 16'h0100, 16'h0000);
            run_frame("after_abort", 16'h0038, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_seq.md
DAC_SEQ -- requirements
Module: dac_seq

Interface
REQ-001 The module SHALL provide parameter SCLK_DIV, default 2, giving CLK_60 cycles per SCLK half-period (legal 1..15).
REQ-002 The module SHALL provide parameter GAP_CYC, default 4, giving CLK_60 cycles of dac_sync_n high between frames (legal 1..15).
REQ-003 The module SHALL provide parameter DAC_CMD, default 8'h30, as the 8-bit command byte of every frame.
REQ-004 CLK_60  input  1  sole clock, 60 MHz; one clock, all logic on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 upd_req  input  1  single-cycle request to write one DAC frame.
REQ-007 speed_code  input  16  signed two's-complement offset from origin, used in normal mode.
REQ-008 dac_org  input  16  unsigned DAC origin (zero-speed) code.
REQ-009 dac_width_10V  input  16  unsigned code span from origin to +10 V.
REQ-010 calib_org  input  1  calibration mode, output the origin.
REQ-011 calib_10V  input  1  calibration mode, output origin plus the +10 V span.
REQ-012 dac_sclk  output  1  DAC serial clock, idle low.
REQ-013 dac_sync_n  output  1  DAC frame select, active low.
REQ-014 dac_din  output  1  DAC serial data, MSB first.
REQ-015 busy  output  1  high while a frame is loading, shifting or in the inter-frame gap.
REQ-016 done  output  1  one-cycle pulse at frame completion.
REQ-017 dac_code  output  16  code of the most recently loaded frame.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SHIFT and GAP.
REQ-019 IDLE SHALL go to LOAD on the next edge when upd_req or the pending flag is set, clearing the pending flag.
REQ-020 LOAD SHALL last 1 cycle:
- sample the code-select inputs and compute the code;
- update dac_code;
- latch the 24-bit frame {DAC_CMD, code};
- go to SHIFT.
REQ-021 Code select priority SHALL be calib_org, then calib_10V, then normal.
- calib_org → dac_org.
- calib_10V → dac_org + dac_width_10V, 17-bit sum, saturated to 16'hFFFF.
- normal → dac_org + sign-extended speed_code, 18-bit signed sum, clamped to 0..65535.
REQ-022 SHIFT SHALL hold dac_sync_n low for exactly 24 bits × 2×SCLK_DIV cycles, 96 at default.
REQ-023 Within each bit period in SHIFT:
- dac_din SHALL be valid for the whole bit period;
- dac_sclk SHALL be low for the first SCLK_DIV cycles and high for the second SCLK_DIV cycles;
- the DAC samples on the rising edge of dac_sclk.
REQ-024 After the last bit, the FSM SHALL enter GAP with dac_sync_n high and dac_sclk low for GAP_CYC cycles, then return to IDLE.
REQ-025 done SHALL pulse, and busy SHALL fall, on the first cycle back in IDLE.
REQ-026 busy SHALL be high from the LOAD cycle through the last GAP cycle.
REQ-027 At default parameters, with upd_req high at cycle 0, LOAD SHALL be cycle 1, SHIFT cycles 2–97, GAP cycles 98–101, and done cycle 102.
REQ-028 upd_req outside IDLE SHALL set the pending flag; any number of requests while busy SHALL collapse into exactly one further frame.
REQ-029 upd_req arriving on the same cycle the FSM returns to IDLE SHALL start the next frame with no request lost.
REQ-030 Input changes after LOAD SHALL NOT affect the frame in flight.

Reset
REQ-031 On RST high at a clock edge, the block SHALL set:
- FSM to IDLE, pending flag to 0;
- dac_sync_n to 1, dac_sclk to 0, dac_din to 0;
- busy to 0, done to 0;
- dac_code to 16'h8000.
REQ-032 RST asserted mid-frame SHALL abort the frame; dac_sync_n SHALL be high on the cycle after the reset edge and no done SHALL be issued.

Structure
REQ-033 Package dac_pkg SHALL hold the FSM state encoding, FRAME_W = 24, the default DAC_CMD and the reset code 16'h8000.
REQ-034 The SCLK divider, bit counter and 24-bit shift register SHALL form sub-module dac_spi_shift, with start, frame, busy and serial outputs; dac_seq holds the FSM, arbitration and arithmetic.

Verification
REQ-035 Reset check: after RST → dac_sync_n = 1, dac_sclk = 0, busy = 0, done = 0, dac_code = 16'h8000.
REQ-036 Origin frame: calib_org = 1, dac_org = 16'h8000, upd_req pulse → frame bits 24'h308000 captured on dac_sclk rising edges; dac_sync_n low for 96 cycles; done at cycle 102.
REQ-037 +10 V frames: calib_10V = 1, dac_org = 32768, dac_width_10V = 27692 → code 16'hEC2C; then dac_org = 16'hC000, dac_width_10V = 32692 → code 16'hFFFF (saturated).
REQ-038 Normal-mode clamp: dac_org = 27768, speed_code = -32768 → code 16'h0000; dac_org = 16'hFFF0, speed_code = +100 → code 16'hFFFF.
REQ-039 Request collapse: three upd_req pulses during SHIFT → exactly two frames and two done pulses; second frame starts on the cycle after the first done.
REQ-040 Mid-frame reset: RST at cycle 50 of SHIFT → dac_sync_n high on the next cycle, no done, and the next upd_req produces a complete 24-bit frame.
